muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the EX stage, owning the architectural HI/LO registers. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the pipeline. Multiplies and divides run as a fixed-latency shift/add or shift/subtract sequence on one shared adder, and `busy` holds the pipeline stalled until the result is written. MFHI/MFLO are served by reading the `hi`/`lo` outputs directly.

---
 rtl/muldiv_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/DIV sequencer owning HI/LO.
// One WIDTH+1 adder is shared: shift/add for multiply, restoring shift/subtract for divide.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    // state | meaning
    // IDLE  | waiting for start; MT writes happen here
    // MUL   | one multiplier bit per cycle
    // DIV   | one quotient bit per cycle
    // FIX   | sign fixup and HI/LO write
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] raw_a_q, raw_a_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic             is_div_q, is_div_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             add_sub;
    logic [WIDTH:0]   add_a, add_b, sum;
    logic [WIDTH:0]   hi_sum;
    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;
    logic             func_known;

    // Divide feeds the shifted remainder plus the next dividend bit; multiply feeds the upper accumulator.
    always_comb begin
        add_sub = (state_q == S_DIV);
        add_a   = add_sub ? {acc_hi_q, acc_lo_q[WIDTH-1]} : {1'b0, acc_hi_q};
        add_b   = {1'b0, opnd_q};
        sum     = add_a + (add_b ^ {(WIDTH+1){add_sub}}) + (WIDTH+1)'(add_sub);
    end

    always_comb begin
        op_signed  = (func == F_MULT) || (func == F_DIV);
        a_neg      = op_signed & op_a[WIDTH-1];
        b_neg      = op_signed & op_b[WIDTH-1];
        abs_a      = a_neg ? -op_a : op_a;
        abs_b      = b_neg ? -op_b : op_b;
        prod       = {acc_hi_q, acc_lo_q};
        func_known = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV)  ||
                     (func == F_DIVU) || (func == F_MTHI)  || (func == F_MTLO) ||
                     (func == F_MFHI) || (func == F_MFLO);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        raw_a_d    = raw_a_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        hi_sum     = {1'b0, acc_hi_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (func)
                        F_MULT, F_MULTU: begin
                            state_d    = S_MUL;
                            cnt_d      = '0;
                            acc_hi_d   = '0;
                            acc_lo_d   = abs_b;
                            opnd_d     = abs_a;
                            raw_a_d    = op_a;
                            sign_quo_d = a_neg ^ b_neg;
                            sign_rem_d = a_neg;
                            is_div_d   = 1'b0;
                            div_zero_d = 1'b0;
                        end
                        F_DIV, F_DIVU: begin
                            state_d    = S_DIV;
                            cnt_d      = '0;
                            acc_hi_d   = '0;
                            acc_lo_d   = abs_a;
                            opnd_d     = abs_b;
                            raw_a_d    = op_a;
                            sign_quo_d = a_neg ^ b_neg;
                            sign_rem_d = a_neg;
                            is_div_d   = 1'b1;
                            div_zero_d = (op_b == '0);
                        end
                        F_MTHI:  hi_d = op_a;
                        F_MTLO:  lo_d = op_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (acc_lo_q[0]) hi_sum = sum;
                acc_hi_d = hi_sum[WIDTH:1];
                acc_lo_d = {hi_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_DIV: begin
                acc_hi_d = sum[WIDTH] ? {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]} : sum[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], ~sum[WIDTH]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = sign_quo_q ? -prod : prod;
                end else if (div_zero_q) begin
                    lo_d = '1;
                    hi_d = raw_a_q;
                end else begin
                    lo_d = sign_quo_q ? -acc_lo_q : acc_lo_q;
                    hi_d = sign_rem_q ? -acc_hi_q : acc_hi_q;
                end
            end
        endcase

        // Flush leaves HI/LO at their pre-operation values and drops any start in the same cycle.
        if (kill) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            raw_a_q    <= raw_a_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_IDLE && start && !kill && !func_known)
            $display("muldiv_ctrl: warning: unsupported func 0x%h ignored", func);
    end
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO, a negedge monitor checks them on done.
module tb_muldiv_ctrl;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    logic        clk, reset, start, kill, busy, done;
    logic [5:0]  func;
    logic [31:0] op_a, op_b, hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_run = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .func  (func),
        .op_a  (op_a),
        .op_b  (op_b),
        .kill  (kill),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
                    check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
                    check({mon_e.name, "_busy_cycles"}, 64'(busy_run), 64'd33);
                    check({mon_e.name, "_busy_at_done"}, 64'(busy), 64'd0);
                end
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end
    end

    task automatic push(input logic [31:0] h, input logic [31:0] l, input string name);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        func  = f;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 60);
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; kill = 1'b0;
        func = 6'h0; op_a = '0; op_b = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        push(32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7_m3");
        issue(F_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_done("mult_7_m3");
        @(posedge clk); #1;

        push(32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max");
        @(posedge clk); #1;

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2");
        push(32'd1, 32'd3, "divu_7_2_b2b");
        issue(F_DIVU, 32'd7, 32'd2);
        wait_done("divu_7_2_b2b");
        @(posedge clk); #1;

        push(32'h1234_5678, 32'hFFFF_FFFF, "div_by_zero");
        issue(F_DIV, 32'h1234_5678, 32'd0);
        wait_done("div_by_zero");
        @(posedge clk); #1;

        push(32'd0, 32'h8000_0000, "div_ovf");
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf");
        @(posedge clk); #1;

        push(32'd2, 32'd14, "divu_100_7");
        issue(F_DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7");
        @(posedge clk); #1;

        issue(F_MTHI, 32'hA, 32'd0);
        check("mthi_hi", 64'(hi), 64'hA);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(F_MTLO, 32'hB, 32'd0);
        check("mtlo_lo", 64'(lo), 64'hB);
        check("mtlo_hi_kept", 64'(hi), 64'hA);

        issue(F_DIV, 32'd100, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; func = F_MTLO; op_a = 32'h55;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_hi", 64'(hi), 64'hA);
        check("kill_lo", 64'(lo), 64'hB);
        repeat (40) @(negedge clk);

        start = 1'b1; func = F_MTHI; op_a = 32'h77; kill = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b0;
        check("kill_start_hi", 64'(hi), 64'hA);
        check("kill_start_busy", 64'(busy), 64'd0);

        issue(F_MULT, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        exp_q.delete();
        check("amid_rst_busy", 64'(busy), 64'd0);
        check("amid_rst_done", 64'(done), 64'd0);
        check("amid_rst_hi",   64'(hi),   64'd0);
        check("amid_rst_lo",   64'(lo),   64'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;
        issue(F_MTHI, 32'h33, 32'd0);
        check("post_rst_mthi", 64'(hi), 64'h33);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
